img_row_fetch_ctrl: RTL
=======================

IMG_ROW_FETCH_CTRL -- requirements
Module: img_row_fetch_ctrl

Interface
REQ-001 Parameter SRC_H, 480, source image height in rows.
REQ-002 Parameter DST_H, 1080, output (HDMI) frame height in rows.
REQ-003 Single clock domain: clk. Reset: rst, asynchronous, active-high.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 i_frame_start  in  1  one-cycle pulse marking the start of an output frame.
REQ-007 i_line_req  in  1  one-cycle pulse requesting processing of the next output row.
REQ-008 o_h_ram_raddr  out  11  row-table read address, equal to the current output row.
REQ-009 o_h_ram_re  out  1  row-table read enable, one-cycle pulse.
REQ-010 i_org_h_vld  in  1  table entry flag: row lies inside the ROI.
REQ-011 i_org_h  in  15  source row, format {10-bit integer, 5-bit fraction}.
REQ-012 i_h_ram_vld  in  1  read data valid; arrives exactly 1 cycle after o_h_ram_re.
REQ-013 o_fetch_vld  out  1  source-row fetch request valid.
REQ-014 i_fetch_rdy  in  1  fetch request accepted.
REQ-015 o_src_row0  out  10  upper source row.
REQ-016 o_src_row1  out  10  lower source row.
REQ-017 o_v_weight  out  5  vertical interpolation weight of row1, in 1/32 units.
REQ-018 o_fetch_repeat  out  1  row0 and row1 are identical to the previous fetch in this frame.
REQ-019 o_blank_line  out  1  one-cycle pulse: current output row is outside the ROI.
REQ-020 o_line_done  out  1  one-cycle pulse: current output row is finished.
REQ-021 o_out_row  out  11  current output row counter.
REQ-022 o_busy  out  1  high in any state other than IDLE.
REQ-023 o_overrun  out  1  sticky error flag.

Function
REQ-024 FSM states: IDLE, RD, WAIT, ISSUE, DONE.
REQ-025 IDLE: if i_line_req=1 and o_out_row<DST_H, go to RD. In the RD cycle, o_h_ram_re=1 and o_h_ram_raddr=o_out_row.
REQ-026 RD always goes to WAIT.
REQ-027 WAIT: when i_h_ram_vld=1, capture the entry.
  - If i_org_h_vld=1, go to ISSUE.
  - If i_org_h_vld=0, go to DONE and assert o_blank_line in the DONE cycle.
REQ-028 Output derivation on capture:
  - o_src_row0 = min(i_org_h[14:5], SRC_H-1).
  - o_src_row1 = min(o_src_row0+1, SRC_H-1).
  - o_v_weight = i_org_h[4:0].
REQ-029 ISSUE: o_fetch_vld=1, with o_src_row0, o_src_row1, o_v_weight and o_fetch_repeat held stable. Leave ISSUE for DONE on the cycle where i_fetch_rdy=1.
REQ-030 o_fetch_repeat=1 when (row0,row1) equals the last accepted fetch pair of the current frame. The first fetch of a frame always has o_fetch_repeat=0.
REQ-031 DONE: o_line_done=1 for one cycle, o_out_row increments, then go to IDLE.
REQ-032 o_out_row saturates at DST_H.
REQ-033 Latency: i_line_req at cycle N gives o_h_ram_re at N+1 and o_fetch_vld at N+3 at the earliest.
REQ-034 i_line_req while o_busy=1 is ignored and sets o_overrun.
REQ-035 i_line_req while o_out_row==DST_H is ignored and sets o_overrun.
REQ-036 i_frame_start aborts from any state on the next edge:
  - state goes to IDLE; o_out_row=0.
  - o_overrun, o_fetch_vld and the repeat history are cleared.
  - An i_line_req in the same cycle is ignored.
REQ-037 i_h_ram_vld in any state other than WAIT is ignored.
REQ-038 All outputs are registered.

Reset
REQ-039 While rst=1: state IDLE; all outputs 0, including o_out_row=0, o_src_row0/1=0 and o_v_weight=0.
REQ-040 rst asserted mid-operation drops o_fetch_vld immediately, with no handshake completion.

Verification
REQ-041 Frame start, then line_req; table entry vld=1, org_h=15'h0C8A -> re at +1 with raddr 0; fetch_vld at +3 with row0=100, row1=101, weight=10; rdy -> line_done, out_row=1.
REQ-042 Entry vld=0 -> no fetch_vld; blank_line and line_done pulse together; out_row increments.
REQ-043 Entry org_h int=479, or int=600 -> row0=479, row1=479 (clamped).
REQ-044 Two consecutive lines with the same org_h int and different fractions -> second fetch has repeat=1; after a new frame_start, repeat=0.
REQ-045 line_req during ISSUE with rdy held low for 5 cycles -> request ignored, overrun=1, fetch_vld stays high and stable; frame_start clears overrun and aborts to IDLE.
REQ-046 1081 line_reqs in one frame -> out_row stops at 1080; 1081st request sets overrun and produces no re.

Source files
------------

// File: rtl/img_row_fetch_ctrl.sv
// Output-row to source-row fetch controller for vertical image scaling.
// Looks up each output row in a row table and issues a two-row fetch.
module img_row_fetch_ctrl #(
  parameter int SRC_H = 480,
  parameter int DST_H = 1080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_start,
  input  logic        i_line_req,
  output logic [10:0] o_h_ram_raddr,
  output logic        o_h_ram_re,
  input  logic        i_org_h_vld,
  input  logic [14:0] i_org_h,
  input  logic        i_h_ram_vld,
  output logic        o_fetch_vld,
  input  logic        i_fetch_rdy,
  output logic [9:0]  o_src_row0,
  output logic [9:0]  o_src_row1,
  output logic [4:0]  o_v_weight,
  output logic        o_fetch_repeat,
  output logic        o_blank_line,
  output logic        o_line_done,
  output logic [10:0] o_out_row,
  output logic        o_busy,
  output logic        o_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    ISSUE,
    DONE
  } state_t;

  localparam logic [9:0]  ROW_MAX = 10'(SRC_H - 1);
  localparam logic [10:0] ROW_END = 11'(DST_H);

  state_t     state;
  logic       hist_vld;
  logic [9:0] last_r0;
  logic [9:0] last_r1;

  logic [9:0] cap_int;
  logic [9:0] cap_r0;
  logic [9:0] cap_r1;
  logic       cap_rep;

  // Clamp both rows to the last source row so the bottom edge replicates.
  always_comb begin
    cap_int = i_org_h[14:5];
    cap_r0  = (cap_int > ROW_MAX) ? ROW_MAX : cap_int;
    cap_r1  = (cap_r0 == ROW_MAX) ? ROW_MAX : cap_r0 + 10'd1;
    cap_rep = hist_vld && (cap_r0 == last_r0) && (cap_r1 == last_r1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      hist_vld       <= 1'b0;
      last_r0        <= '0;
      last_r1        <= '0;
      o_h_ram_raddr  <= '0;
      o_h_ram_re     <= 1'b0;
      o_fetch_vld    <= 1'b0;
      o_src_row0     <= '0;
      o_src_row1     <= '0;
      o_v_weight     <= '0;
      o_fetch_repeat <= 1'b0;
      o_blank_line   <= 1'b0;
      o_line_done    <= 1'b0;
      o_out_row      <= '0;
      o_busy         <= 1'b0;
      o_overrun      <= 1'b0;
    end else if (i_frame_start) begin
      state          <= IDLE;
      hist_vld       <= 1'b0;
      o_h_ram_re     <= 1'b0;
      o_fetch_vld    <= 1'b0;
      o_fetch_repeat <= 1'b0;
      o_blank_line   <= 1'b0;
      o_line_done    <= 1'b0;
      o_out_row      <= '0;
      o_busy         <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      o_h_ram_re   <= 1'b0;
      o_blank_line <= 1'b0;
      o_line_done  <= 1'b0;
      if (i_line_req && (state != IDLE || o_out_row == ROW_END))
        o_overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (i_line_req && o_out_row != ROW_END) begin
            state         <= RD;
            o_h_ram_re    <= 1'b1;
            o_h_ram_raddr <= o_out_row;
            o_busy        <= 1'b1;
          end
        end
        RD: state <= WAIT;
        WAIT: begin
          if (i_h_ram_vld) begin
            o_src_row0     <= cap_r0;
            o_src_row1     <= cap_r1;
            o_v_weight     <= i_org_h[4:0];
            o_fetch_repeat <= cap_rep;
            if (i_org_h_vld) begin
              state       <= ISSUE;
              o_fetch_vld <= 1'b1;
            end else begin
              state        <= DONE;
              o_blank_line <= 1'b1;
              o_line_done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (i_fetch_rdy) begin
            state       <= DONE;
            o_fetch_vld <= 1'b0;
            o_line_done <= 1'b1;
            hist_vld    <= 1'b1;
            last_r0     <= o_src_row0;
            last_r1     <= o_src_row1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          if (o_out_row != ROW_END)
            o_out_row <= o_out_row + 11'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
